note_display_ctrl: RTL and testbench

- Sits directly upstream of the note-glyph drawer (the 12x12 sharp/letter/octave renderer) and between it and the 160x120, 3-bit-colour VGA adapter.
- Watches the detected note and octave and waits until they are stable.
- On a change, it erases the 36x12 glyph box by writing black pixels, then enables the glyph drawer for a fixed window and forwards the drawer's pixel stream to the adapter.
- Outside the draw window, drawer output is gated off, so the drawer's own blank-screen behaviour never reaches the frame buffer.

---
 rtl/note_display_ctrl_if.sv | 22 ++
 rtl/note_display_ctrl.sv | 151 +++++++++++++++
 tb/tb_note_display_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_display_ctrl_if.sv
// Pixel bus between the glyph drawer, this controller and the VGA adapter.
// The controller (master) consumes the drawer's d_* stream and drives the adapter side.
interface note_display_ctrl_if;
    logic [7:0] d_x_out;
    logic [6:0] d_y_out;
    logic       d_writeEn;
    logic [2:0] d_colour;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic       writeEn;
    logic [2:0] colour;

    modport master (
        input  d_x_out, d_y_out, d_writeEn, d_colour,
        output x_out, y_out, writeEn, colour
    );

    modport slave (
        output d_x_out, d_y_out, d_writeEn, d_colour,
        input  x_out, y_out, writeEn, colour
    );
endinterface

// File: rtl/note_display_ctrl.sv
// Debounces the detected note/octave, blanks the 36x12 glyph box, then lets the
// glyph drawer run for a fixed window while forwarding its pixels to the VGA adapter.
//
// state  | meaning
// IDLE   | shown glyph matches input, nothing written
// STABLE | input differs from shown, waiting for it to hold
// ERASE  | writing 432 black pixels over the glyph box
// DRAW   | drawer enabled, its pixel stream passed through
module note_display_ctrl #(
    parameter logic [7:0] X0            = 8'd10,
    parameter logic [6:0] Y0            = 7'd10,
    parameter int         STABLE_CYCLES = 16,
    parameter int         DRAW_CYCLES   = 512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 note_in,
    input  logic [1:0]                 octave_in,
    output logic [3:0]                 note,
    output logic [1:0]                 octave,
    output logic [7:0]                 x,
    output logic [6:0]                 y,
    output logic                       draw_en,
    output logic                       busy,
    note_display_ctrl_if.master        pix
);
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int DW = $clog2(DRAW_CYCLES);
    localparam logic [SW-1:0] STAB_PRE  = SW'(STABLE_CYCLES - 2);
    localparam logic [DW-1:0] DRAW_LAST = DW'(DRAW_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STABLE, ERASE, DRAW} state_t;

    state_t        state;
    logic [3:0]    shown_note, cand_note;
    logic [1:0]    shown_oct, cand_oct;
    logic [SW-1:0] stab_cnt;
    logic [DW-1:0] dr_cnt;
    logic [5:0]    ex;
    logic [3:0]    ey;

    logic [3:0] note_eff;
    logic [1:0] oct_eff;
    logic       diff_shown, diff_cand;

    // Silence and invalid codes collapse to 0; octave is irrelevant while silent.
    assign note_eff   = (note_in > 4'd12) ? 4'd0 : note_in;
    assign oct_eff    = (note_eff == 4'd0) ? shown_oct : octave_in;
    assign diff_shown = {note_eff, oct_eff} != {shown_note, shown_oct};
    assign diff_cand  = {note_eff, oct_eff} != {cand_note, cand_oct};

    assign x = X0;
    assign y = Y0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            shown_note  <= 4'd0;
            shown_oct   <= 2'd0;
            cand_note   <= 4'd0;
            cand_oct    <= 2'd0;
            stab_cnt    <= '0;
            dr_cnt      <= '0;
            ex          <= 6'd0;
            ey          <= 4'd0;
            note        <= 4'd0;
            octave      <= 2'd0;
            draw_en     <= 1'b0;
            busy        <= 1'b0;
            pix.x_out   <= 8'd0;
            pix.y_out   <= 7'd0;
            pix.writeEn <= 1'b0;
            pix.colour  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    pix.writeEn <= 1'b0;
                    if (diff_shown) begin
                        cand_note <= note_eff;
                        cand_oct  <= oct_eff;
                        stab_cnt  <= '0;
                        state     <= STABLE;
                        busy      <= 1'b1;
                    end
                end
                STABLE: begin
                    pix.writeEn <= 1'b0;
                    // Returning to the shown value must win over a candidate reload.
                    if (!diff_shown) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (diff_cand) begin
                        cand_note <= note_eff;
                        cand_oct  <= oct_eff;
                        stab_cnt  <= '0;
                    end else if (stab_cnt == STAB_PRE) begin
                        state <= ERASE;
                        ex    <= 6'd0;
                        ey    <= 4'd0;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                ERASE: begin
                    pix.writeEn <= 1'b1;
                    pix.colour  <= 3'd0;
                    pix.x_out   <= X0 + {2'b00, ex};
                    pix.y_out   <= Y0 + {3'b000, ey};
                    if (ex == 6'd35) begin
                        ex <= 6'd0;
                        if (ey == 4'd11) begin
                            ey         <= 4'd0;
                            shown_note <= cand_note;
                            shown_oct  <= cand_oct;
                            note       <= cand_note;
                            octave     <= cand_oct;
                            if (cand_note != 4'd0) begin
                                state   <= DRAW;
                                draw_en <= 1'b1;
                                dr_cnt  <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            ey <= ey + 1'b1;
                        end
                    end else begin
                        ex <= ex + 1'b1;
                    end
                end
                DRAW: begin
                    if (dr_cnt == DRAW_LAST) begin
                        pix.writeEn <= 1'b0;
                        draw_en     <= 1'b0;
                        busy        <= 1'b0;
                        dr_cnt      <= '0;
                        state       <= IDLE;
                    end else begin
                        pix.x_out   <= pix.d_x_out;
                        pix.y_out   <= pix.d_y_out;
                        pix.writeEn <= pix.d_writeEn;
                        pix.colour  <= pix.d_colour;
                        dr_cnt      <= dr_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_display_ctrl.sv
// Scoreboard bench: expected VGA writes are queued as stimulus/drawer pixels are produced
// and popped as the controller emits them; scenario tasks check timing and control outputs.
module tb_note_display_ctrl;
    localparam logic [7:0] X0 = 8'd10;
    localparam logic [6:0] Y0 = 7'd10;
    localparam int SC = 16;
    localparam int DC = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] note_in = 4'd0;
    logic [1:0] octave_in = 2'd0;
    logic [3:0] note;
    logic [1:0] octave;
    logic [7:0] x;
    logic [6:0] y;
    logic       draw_en, busy;

    note_display_ctrl_if pix();

    note_display_ctrl #(.X0(X0), .Y0(Y0), .STABLE_CYCLES(SC), .DRAW_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .note_in(note_in), .octave_in(octave_in),
        .note(note), .octave(octave), .x(x), .y(y),
        .draw_en(draw_en), .busy(busy), .pix(pix)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   dcnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drawer model: sparse pixels early in the window; garbage writes while held in reset.
    always @(negedge clk) begin
        if (draw_en === 1'b1) begin
            pix.d_x_out   = 8'(dcnt + 20);
            pix.d_y_out   = 7'(dcnt % 100);
            pix.d_colour  = 3'(dcnt % 7 + 1);
            pix.d_writeEn = (dcnt < 300) && (dcnt % 2 == 1);
            if (pix.d_writeEn) exp_q.push_back('{pix.d_x_out, pix.d_y_out, pix.d_colour});
            dcnt++;
        end else begin
            dcnt          = 0;
            pix.d_x_out   = 8'd200;
            pix.d_y_out   = 7'd100;
            pix.d_colour  = 3'd7;
            pix.d_writeEn = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (pix.writeEn === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got x=%0d y=%0d c=%0d expected no write",
                         pix.x_out, pix.y_out, pix.colour);
            end else begin
                mon_e = exp_q.pop_front();
                if ({pix.x_out, pix.y_out, pix.colour} !== mon_e) begin
                    errors++;
                    $display("FAIL pixel got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                             pix.x_out, pix.y_out, pix.colour, mon_e.x, mon_e.y, mon_e.c);
                end
            end
        end
    end

    task automatic push_erase();
        for (int ey = 0; ey < 12; ey++)
            for (int ex = 0; ex < 36; ex++)
                exp_q.push_back('{X0 + 8'(ex), Y0 + 7'(ey), 3'd0});
    endtask

    task automatic test_reset();
        reset = 1'b0;
        note_in = 4'd0;
        octave_in = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({note, octave, draw_en, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %h expected 00", {note, octave, draw_en, busy});
        end
        checks++;
        if ({pix.x_out, pix.y_out, pix.writeEn, pix.colour} !== 19'h0) begin
            errors++;
            $display("FAIL reset_pix got %h expected 0", {pix.x_out, pix.y_out, pix.writeEn, pix.colour});
        end
        checks++;
        if (x !== X0 || y !== Y0) begin
            errors++;
            $display("FAIL origin got %0d,%0d expected %0d,%0d", x, y, X0, Y0);
        end
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || draw_en !== 1'b0 || pix.writeEn !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet got busy=%b draw_en=%b writeEn=%b expected 0 0 0",
                         busy, draw_en, pix.writeEn);
            end
        end
    endtask

    // Applies an input at the current negedge and follows one full erase (and draw).
    task automatic do_redraw(input logic [3:0] n, input logic [1:0] o,
                             input logic [3:0] nexp, input bit drawn);
        int t0, tw, len;
        bit seen, de;
        note_in = n;
        octave_in = o;
        t0 = cyc;
        push_erase();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise got %b expected 1", busy);
        end
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (pix.writeEn === 1'b1) seen = 1;
            else @(negedge clk);
        end
        tw = cyc;
        checks++;
        if (!seen || tw != t0 + 1 + SC) begin
            errors++;
            $display("FAIL erase_start got delay %0d expected %0d", tw - t0, 1 + SC);
        end
        if (drawn) begin
            seen = 0;
            for (int i = 0; i < 600 && !seen; i++) begin
                if (draw_en === 1'b1) seen = 1;
                else @(negedge clk);
            end
            checks++;
            if (!seen || cyc != tw + 431) begin
                errors++;
                $display("FAIL draw_start got %0d expected %0d", cyc - tw, 431);
            end
            checks++;
            if (note !== nexp || octave !== o) begin
                errors++;
                $display("FAIL draw_note got %0d/%0d expected %0d/%0d", note, octave, nexp, o);
            end
            len = 0;
            while (draw_en === 1'b1 && len < 1000) begin
                len++;
                @(negedge clk);
            end
            checks++;
            if (len != DC) begin
                errors++;
                $display("FAIL draw_len got %0d expected %0d", len, DC);
            end
            checks++;
            if (pix.writeEn !== 1'b0 || note !== nexp) begin
                errors++;
                $display("FAIL draw_end got writeEn=%b note=%0d expected 0 %0d", pix.writeEn, note, nexp);
            end
        end else begin
            len = 0;
            de = 0;
            while (busy === 1'b1 && len < 600) begin
                if (draw_en === 1'b1) de = 1;
                len++;
                @(negedge clk);
            end
            @(negedge clk);
            checks++;
            if (de || busy !== 1'b0 || draw_en !== 1'b0) begin
                errors++;
                $display("FAIL no_draw got draw_seen=%b busy=%b expected 0 0", de, busy);
            end
            checks++;
            if (note !== nexp) begin
                errors++;
                $display("FAIL shown_silent got %0d expected %0d", note, nexp);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_first_draw();
        do_redraw(4'd1, 2'd2, 4'd1, 1'b1);
    endtask

    task automatic test_glitch();
        note_in = 4'd5;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy got %b expected 1", busy);
        end
        note_in = 4'd1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_return got busy=%b expected 0", busy);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || draw_en !== 1'b0) begin
                errors++;
                $display("FAIL glitch_quiet got busy=%b draw_en=%b expected 0 0", busy, draw_en);
            end
        end
    endtask

    task automatic test_change_during_erase();
        int cnt, guard;
        bit seen;
        note_in = 4'd5;
        octave_in = 2'd2;
        push_erase();
        cnt = 0;
        guard = 0;
        while (cnt < 100 && guard < 300) begin
            @(negedge clk);
            if (pix.writeEn === 1'b1) cnt++;
            guard++;
        end
        note_in = 4'd6;
        seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            if (draw_en === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || note !== 4'd5) begin
            errors++;
            $display("FAIL erase_ignores_change got seen=%b note=%0d expected 1 5", seen, note);
        end
        guard = 0;
        while (draw_en === 1'b1 && guard < 1000) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (guard != DC) begin
            errors++;
            $display("FAIL draw5_len got %0d expected %0d", guard, DC);
        end
        do_redraw(4'd6, 2'd2, 4'd6, 1'b1);
    endtask

    task automatic test_silence();
        do_redraw(4'd3, 2'd2, 4'd3, 1'b1);
        do_redraw(4'd0, 2'd1, 4'd0, 1'b0);
        note_in = 4'd14;
        octave_in = 2'd3;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL invalid_as_silence got busy=%b expected 0", busy);
            end
        end
        do_redraw(4'd3, 2'd1, 4'd3, 1'b1);
        do_redraw(4'd14, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic test_reset_mid_draw();
        bit seen;
        note_in = 4'd7;
        octave_in = 2'd3;
        push_erase();
        seen = 0;
        for (int i = 0; i < 1100 && !seen; i++) begin
            @(negedge clk);
            if (draw_en === 1'b1) seen = 1;
        end
        repeat (200) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || draw_en !== 1'b0 || pix.writeEn !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_ctrl got seen=%b draw_en=%b writeEn=%b busy=%b expected 1 0 0 0",
                     seen, draw_en, pix.writeEn, busy);
        end
        checks++;
        if (note !== 4'd0 || octave !== 2'd0) begin
            errors++;
            $display("FAIL abort_shown got %0d/%0d expected 0/0", note, octave);
        end
        exp_q.delete();
        reset = 1'b1;
        do_redraw(4'd7, 2'd3, 4'd7, 1'b1);
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_glitch();
        test_change_during_erase();
        test_silence();
        test_reset_mid_draw();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end
endmodule
